// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD frame capture path: FSM encodings,
// parameter-bus width and the layout of a word held in the output FIFO.
package ccd_pkg;

    localparam int PARAM_W = 16;

    // FSM encodings kept as plain constants so older tools can consume them.
    typedef logic [1:0] ccd_state_t;
    localparam ccd_state_t ST_IDLE   = 2'd0;
    localparam ccd_state_t ST_HEADER = 2'd1;
    localparam ccd_state_t ST_IMAGE  = 2'd2;
    localparam ccd_state_t ST_DONE   = 2'd3;

    // A FIFO word is {flags, data}; the flags sit above the DATA_W data bits.
    typedef struct packed {
        logic hdr;
        logic sof;
        logic eol;
    } ccd_flags_t;

    localparam int FLAG_W = $bits(ccd_flags_t);

endpackage

// File: rtl/ccd_frame_capture_sync_fifo.sv
// Single-clock FIFO with a registered output stage. The output register counts
// toward DEPTH, so exactly DEPTH words can be held in total.
module sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wrEn,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic             i_rdReady,
    output logic [WIDTH-1:0] o_rdData,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             r_outValid;
    logic [WIDTH-1:0] r_outData;

    logic             w_pop;
    logic             w_wr;
    logic             w_load;
    logic [AW:0]      w_memCount;

    // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken.
    assign w_pop      = r_outValid & i_rdReady;
    assign o_full     = (r_count == DEPTH_CNT);
    assign w_wr       = i_wrEn & (~o_full | w_pop);
    assign w_memCount = r_count - {{AW{1'b0}}, r_outValid};
    assign w_load     = (w_memCount != '0) & (~r_outValid | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else begin
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_load) begin
                r_outData  <= r_mem[r_rdPtr];
                r_rdPtr    <= r_rdPtr + AW'(1);
                r_outValid <= 1'b1;
            end else if (w_pop) begin
                r_outValid <= 1'b0;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdData = r_outData;
    assign o_empty  = ~r_outValid;

endmodule

// File: rtl/ccd_frame_capture.sv
// Receive side of the CCD readout: classifies ADC words as header or image,
// crops image words to the active window and streams them out through a FIFO.
module ccd_frame_capture
    import ccd_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               VA,
    input  logic               HDR_ENABLE,
    input  logic               HDR_ADC_W,
    input  logic [DATA_W-1:0]  ADC_DATA,
    input  logic [PARAM_W-1:0] PARAM_X,
    input  logic [PARAM_W-1:0] PARAM_Y,
    input  logic [PARAM_W-1:0] PARAM_OFFSET_X,
    input  logic [PARAM_W-1:0] PARAM_OFFSET_Y,
    input  logic [PARAM_W-1:0] PARAM_ACTIVE_X,
    input  logic [PARAM_W-1:0] PARAM_ACTIVE_Y,
    output logic [DATA_W-1:0]  M_DATA,
    output logic               M_VALID,
    input  logic               M_READY,
    output logic               M_HDR,
    output logic               M_SOF,
    output logic               M_EOL,
    output logic               FRAME_DONE,
    output logic               FRAME_ERR,
    output logic               OVERFLOW
);

    localparam int WORD_W = DATA_W + FLAG_W;

    ccd_state_t         r_state;
    logic               r_vaQ;
    logic               r_vaQ2;
    logic [PARAM_W-1:0] r_x;
    logic [PARAM_W-1:0] r_y;
    logic [PARAM_W-1:0] r_px;
    logic [PARAM_W-1:0] r_py;
    logic [PARAM_W-1:0] r_offX;
    logic [PARAM_W-1:0] r_offY;
    logic [PARAM_W-1:0] r_actX;
    logic [PARAM_W-1:0] r_actY;
    logic               r_sofPending;
    logic               r_frameErr;
    logic               r_overflow;

    logic               w_vaRise;
    logic               w_vaFall;
    logic               w_inFrame;
    logic               w_strobe;
    logic               w_hdrWord;
    logic               w_imgWord;
    logic [PARAM_W:0]   w_x17;
    logic [PARAM_W:0]   w_y17;
    logic [PARAM_W:0]   w_xEnd;
    logic [PARAM_W:0]   w_yEnd;
    logic               w_inWin;
    logic               w_eol;
    logic               w_lastX;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    ccd_flags_t         w_flags;
    logic [WORD_W-1:0]  w_fifoIn;
    logic [WORD_W-1:0]  w_fifoOut;
    logic               w_fifoFull;
    logic               w_fifoEmpty;

    assign w_vaRise  = r_vaQ & ~r_vaQ2;
    assign w_vaFall  = ~r_vaQ & r_vaQ2;
    assign w_inFrame = ((r_state == ST_HEADER) || (r_state == ST_IMAGE)) && !w_vaFall;
    assign w_strobe  = HDR_ADC_W & w_inFrame;
    assign w_hdrWord = w_strobe & (r_state == ST_HEADER) & HDR_ENABLE;
    assign w_imgWord = w_strobe & ~w_hdrWord;

    // 17-bit window arithmetic so origin + size never wraps.
    assign w_x17   = {1'b0, r_x};
    assign w_y17   = {1'b0, r_y};
    assign w_xEnd  = {1'b0, r_offX} + {1'b0, r_actX};
    assign w_yEnd  = {1'b0, r_offY} + {1'b0, r_actY};
    assign w_inWin = (w_x17 >= {1'b0, r_offX}) && (w_x17 < w_xEnd) &&
                     (w_y17 >= {1'b0, r_offY}) && (w_y17 < w_yEnd);
    assign w_eol   = (w_x17 == w_xEnd - 17'd1);
    assign w_lastX = (w_x17 == {1'b0, r_px} - 17'd1);

    assign w_push    = w_hdrWord | (w_imgWord & w_inWin);
    assign w_pop     = M_VALID & M_READY;
    assign w_drop    = w_push & w_fifoFull & ~w_pop;
    assign w_flags   = '{hdr: w_hdrWord, sof: w_imgWord & r_sofPending, eol: w_imgWord & w_eol};
    assign w_fifoIn  = {w_flags, ADC_DATA};

    // VA edge detectors start high after reset so a VA already high needs a fresh rise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_vaQ        <= 1'b1;
            r_vaQ2       <= 1'b1;
            r_x          <= '0;
            r_y          <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_offX       <= '0;
            r_offY       <= '0;
            r_actX       <= '0;
            r_actY       <= '0;
            r_sofPending <= 1'b0;
            r_frameErr   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_vaQ  <= VA;
            r_vaQ2 <= r_vaQ;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_vaRise) begin
                        r_state      <= ST_HEADER;
                        r_px         <= PARAM_X;
                        r_py         <= PARAM_Y;
                        r_offX       <= PARAM_OFFSET_X;
                        r_offY       <= PARAM_OFFSET_Y;
                        r_actX       <= PARAM_ACTIVE_X;
                        r_actY       <= PARAM_ACTIVE_Y;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_sofPending <= 1'b1;
                        r_frameErr   <= 1'b0;
                        r_overflow   <= 1'b0;
                    end
                end
                ST_HEADER, ST_IMAGE: begin
                    if (w_vaFall) begin
                        r_state    <= ST_DONE;
                        r_frameErr <= (r_x != '0) || (r_y != r_py);
                    end else if (w_imgWord) begin
                        r_state <= ST_IMAGE;
                        if (w_inWin) begin
                            r_sofPending <= 1'b0;
                        end
                        if (w_lastX) begin
                            r_x <= '0;
                            r_y <= r_y + PARAM_W'(1);
                        end else begin
                            r_x <= r_x + PARAM_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_wrEn    (w_push),
        .i_wrData  (w_fifoIn),
        .i_rdReady (M_READY),
        .o_rdData  (w_fifoOut),
        .o_full    (w_fifoFull),
        .o_empty   (w_fifoEmpty)
    );

    assign {M_HDR, M_SOF, M_EOL, M_DATA} = w_fifoOut;
    assign M_VALID    = ~w_fifoEmpty;
    assign FRAME_DONE = (r_state == ST_DONE);
    assign FRAME_ERR  = r_frameErr;
    assign OVERFLOW   = r_overflow;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Scoreboard bench for ccd_frame_capture on an 8x4 frame with directed
// window/backpressure/reset scenarios and a 4-deep output FIFO.
module tb_ccd_frame_capture;

    logic        CLK = 1'b0;
    logic        RST;
    logic        VA;
    logic        HDR_ENABLE;
    logic        HDR_ADC_W;
    logic [15:0] ADC_DATA;
    logic [15:0] PARAM_X;
    logic [15:0] PARAM_Y;
    logic [15:0] PARAM_OFFSET_X;
    logic [15:0] PARAM_OFFSET_Y;
    logic [15:0] PARAM_ACTIVE_X;
    logic [15:0] PARAM_ACTIVE_Y;
    logic [15:0] M_DATA;
    logic        M_VALID;
    logic        M_READY;
    logic        M_HDR;
    logic        M_SOF;
    logic        M_EOL;
    logic        FRAME_DONE;
    logic        FRAME_ERR;
    logic        OVERFLOW;

    int checks = 0;
    int errors = 0;
    logic [18:0] expQ[$];

    ccd_frame_capture #(
        .DATA_W     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .VA             (VA),
        .HDR_ENABLE     (HDR_ENABLE),
        .HDR_ADC_W      (HDR_ADC_W),
        .ADC_DATA       (ADC_DATA),
        .PARAM_X        (PARAM_X),
        .PARAM_Y        (PARAM_Y),
        .PARAM_OFFSET_X (PARAM_OFFSET_X),
        .PARAM_OFFSET_Y (PARAM_OFFSET_Y),
        .PARAM_ACTIVE_X (PARAM_ACTIVE_X),
        .PARAM_ACTIVE_Y (PARAM_ACTIVE_Y),
        .M_DATA         (M_DATA),
        .M_VALID        (M_VALID),
        .M_READY        (M_READY),
        .M_HDR          (M_HDR),
        .M_SOF          (M_SOF),
        .M_EOL          (M_EOL),
        .FRAME_DONE     (FRAME_DONE),
        .FRAME_ERR      (FRAME_ERR),
        .OVERFLOW       (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Monitor: every accepted stream word must match the head of the expected queue.
    always @(negedge CLK) begin
        logic [18:0] exp;
        if (M_VALID && M_READY) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL stream unexpected word: got hdr/sof/eol/data=%b/%b/%b/%h, none expected",
                         M_HDR, M_SOF, M_EOL, M_DATA);
            end else begin
                exp = expQ.pop_front();
                if ({M_HDR, M_SOF, M_EOL, M_DATA} !== exp) begin
                    errors++;
                    $display("[TB] FAIL stream word: got hdr/sof/eol/data=%b/%b/%b/%h expected %b/%b/%b/%h",
                             M_HDR, M_SOF, M_EOL, M_DATA, exp[18], exp[17], exp[16], exp[15:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] pix(input int x, input int y);
        return 16'((y << 8) | x);
    endfunction

    function automatic void pushExp(input logic hdr, input logic sof, input logic eol, input logic [15:0] data);
        expQ.push_back({hdr, sof, eol, data});
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One ADC strobe lasting exactly one clock; back-to-back calls give one strobe per cycle.
    task automatic applyStimulus(input logic hdrEn, input logic [15:0] data);
        HDR_ADC_W  = 1'b1;
        HDR_ENABLE = hdrEn;
        ADC_DATA   = data;
        @(posedge CLK);
        #1;
        HDR_ADC_W  = 1'b0;
        HDR_ENABLE = 1'b0;
    endtask

    task automatic imageFrame(input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b0, pix(i % 8, i / 8));
        end
    endtask

    task automatic startFrame(input logic [15:0] ox, input logic [15:0] oy,
                              input logic [15:0] ax, input logic [15:0] ay);
        PARAM_X        = 16'd8;
        PARAM_Y        = 16'd4;
        PARAM_OFFSET_X = ox;
        PARAM_OFFSET_Y = oy;
        PARAM_ACTIVE_X = ax;
        PARAM_ACTIVE_Y = ay;
        VA = 1'b1;
        idle(3);
    endtask

    task automatic endFrame(input logic expErr);
        VA = 1'b0;
        idle(1);
        checkOutput("frame_done early", FRAME_DONE, 0);
        idle(1);
        checkOutput("frame_done pulse", FRAME_DONE, 1);
        checkOutput("frame_err", FRAME_ERR, expErr);
        idle(1);
        checkOutput("frame_done one cycle", FRAME_DONE, 0);
        idle(2);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 500) begin
            idle(1);
            n++;
        end
        checkOutput("drain remaining words", expQ.size(), 0);
        idle(3);
        checkOutput("valid after drain", M_VALID, 0);
    endtask

    initial begin
        RST = 1'b1; VA = 1'b0; HDR_ENABLE = 1'b0; HDR_ADC_W = 1'b0; ADC_DATA = '0;
        PARAM_X = '0; PARAM_Y = '0; PARAM_OFFSET_X = '0; PARAM_OFFSET_Y = '0;
        PARAM_ACTIVE_X = '0; PARAM_ACTIVE_Y = '0; M_READY = 1'b1;
        idle(3);
        RST = 1'b0;
        checkOutput("reset m_valid", M_VALID, 0);
        checkOutput("reset m_data", {M_HDR, M_SOF, M_EOL, M_DATA}, 0);
        checkOutput("reset frame_done", FRAME_DONE, 0);
        checkOutput("reset frame_err", FRAME_ERR, 0);
        checkOutput("reset overflow", OVERFLOW, 0);
        idle(3);

        $display("[TB] basic frame");
        startFrame(16'd2, 16'd1, 16'd4, 16'd2);
        pushExp(1, 0, 0, 16'hA000);
        pushExp(1, 0, 0, 16'hA001);
        for (int y = 1; y <= 2; y++)
            for (int x = 2; x <= 5; x++)
                pushExp(0, (y == 1 && x == 2), (x == 5), pix(x, y));
        applyStimulus(1'b1, 16'hA000);
        checkOutput("valid not yet at n+1", M_VALID, 0);
        applyStimulus(1'b1, 16'hA001);
        checkOutput("valid at n+2", M_VALID, 1);
        checkOutput("first word at n+2", {M_HDR, M_DATA}, {1'b1, 16'hA000});
        imageFrame(32);
        endFrame(1'b0);
        waitDrain();
        checkOutput("basic overflow", OVERFLOW, 0);

        $display("[TB] short frame");
        startFrame(16'd2, 16'd1, 16'd4, 16'd2);
        for (int y = 1; y <= 2; y++)
            for (int x = 2; x <= 5; x++)
                pushExp(0, (y == 1 && x == 2), (x == 5), pix(x, y));
        imageFrame(29);
        endFrame(1'b1);
        waitDrain();

        $display("[TB] window at frame edge");
        startFrame(16'd0, 16'd1, 16'd8, 16'd2);
        checkOutput("frame_err cleared at va rise", FRAME_ERR, 0);
        for (int y = 1; y <= 2; y++)
            for (int x = 0; x <= 7; x++)
                pushExp(0, (y == 1 && x == 0), (x == 7), pix(x, y));
        imageFrame(32);
        endFrame(1'b0);
        waitDrain();

        $display("[TB] backpressure");
        M_READY = 1'b0;
        startFrame(16'd2, 16'd1, 16'd4, 16'd2);
        pushExp(1, 0, 0, 16'hA200);
        pushExp(1, 0, 0, 16'hA201);
        pushExp(0, 1, 0, pix(2, 1));
        pushExp(0, 0, 0, pix(3, 1));
        applyStimulus(1'b1, 16'hA200);
        applyStimulus(1'b1, 16'hA201);
        idle(1);
        checkOutput("held word early", {M_VALID, M_HDR, M_DATA}, {2'b11, 16'hA200});
        imageFrame(32);
        checkOutput("held word late", {M_VALID, M_HDR, M_DATA}, {2'b11, 16'hA200});
        endFrame(1'b0);
        checkOutput("overflow sticky", OVERFLOW, 1);
        M_READY = 1'b1;
        waitDrain();
        checkOutput("overflow persists after drain", OVERFLOW, 1);

        $display("[TB] full fifo push and pop");
        M_READY = 1'b0;
        startFrame(16'd2, 16'd1, 16'd4, 16'd2);
        checkOutput("overflow cleared at va rise", OVERFLOW, 0);
        for (int i = 0; i < 5; i++)
            pushExp(1, 0, 0, 16'hA300 + 16'(i));
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 16'hA300 + 16'(i));
        M_READY = 1'b1;
        applyStimulus(1'b1, 16'hA304);
        checkOutput("no overflow on push+pop when full", OVERFLOW, 0);
        waitDrain();
        endFrame(1'b1);

        $display("[TB] reset mid-frame");
        M_READY = 1'b0;
        startFrame(16'd2, 16'd1, 16'd4, 16'd2);
        applyStimulus(1'b1, 16'hA500);
        imageFrame(10);
        checkOutput("fifo holds header before reset", M_VALID, 1);
        RST = 1'b1;
        applyStimulus(1'b0, pix(2, 1));
        RST = 1'b0;
        checkOutput("valid after reset", M_VALID, 0);
        checkOutput("stream after reset", {M_HDR, M_SOF, M_EOL, M_DATA}, 0);
        checkOutput("stickies after reset", {FRAME_DONE, FRAME_ERR, OVERFLOW}, 0);
        M_READY = 1'b1;
        for (int x = 3; x <= 5; x++)
            applyStimulus(1'b1, pix(x, 1));
        idle(3);
        checkOutput("strobes ignored after reset", M_VALID, 0);
        VA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            checkOutput("no frame_done without frame", FRAME_DONE, 0);
        end
        idle(2);

        $display("[TB] frame after reset");
        startFrame(16'd2, 16'd1, 16'd4, 16'd2);
        pushExp(1, 0, 0, 16'hA600);
        applyStimulus(1'b1, 16'hA600);
        endFrame(1'b1);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccd_frame_capture.md
# ccd_frame_capture

Receive side of the CCD readout timing generator. Samples the ADC data bus on each ADC write strobe during a readout, separates header words from image words, and tracks column and row position. Crops image words to the active window and pushes header and window words through a small FIFO onto a valid/ready pixel stream with start-of-frame and end-of-line markers. Sits between the timing generator/ADC and the frame-buffer DMA.

## Interface
Parameters:
- DATA_W, 16, ADC word width
- FIFO_DEPTH, 16, output FIFO depth in words; power of 2, ≥4

Ports:
- CLK  in  1  single clock (timing generator clock)
- RST  in  1  synchronous, active-high reset
- VA  in  1  readout active; rising edge starts a frame, falling edge ends it
- HDR_ENABLE  in  1  high while header words are being written
- HDR_ADC_W  in  1  one-cycle ADC word strobe; ADC_DATA valid in the same cycle
- ADC_DATA  in  DATA_W  ADC sample
- PARAM_X, PARAM_Y  in  16  words per line, lines per frame
- PARAM_OFFSET_X, PARAM_OFFSET_Y  in  16  active window origin
- PARAM_ACTIVE_X, PARAM_ACTIVE_Y  in  16  active window size
- M_DATA  out  DATA_W  stream word
- M_VALID  out  1  stream valid
- M_READY  in  1  stream ready
- M_HDR  out  1  word is a header word
- M_SOF  out  1  first window word of the frame
- M_EOL  out  1  last window word of a line
- FRAME_DONE  out  1  one-cycle pulse at frame end
- FRAME_ERR  out  1  sticky: frame ended with line count ≠ PARAM_Y or line word count ≠ PARAM_X
- OVERFLOW  out  1  sticky: word dropped because FIFO full

## Operation
- Reset: all outputs 0, FSM IDLE, counters 0, FIFO empty, stickies cleared.
- FSM states: IDLE, HEADER, IMAGE, DONE.
- IDLE → HEADER on VA rise, detected from the registered VA. PARAM_* are latched at VA rise and held for the frame. x and y are set to 0. FRAME_ERR and OVERFLOW are cleared.
- HEADER: each strobe with HDR_ENABLE=1 is pushed with M_HDR=1. The first strobe with HDR_ENABLE=0 moves to IMAGE and is processed as an image word in the same cycle.
- IMAGE: each strobe is an image word at (x, y).
  - The word is pushed only if OFFSET_X ≤ x < OFFSET_X+ACTIVE_X and OFFSET_Y ≤ y < OFFSET_Y+ACTIVE_Y.
  - M_SOF is set on the first pushed word of the frame.
  - M_EOL is set when x = OFFSET_X+ACTIVE_X−1.
  - When x = PARAM_X−1, x wraps to 0 and y increments; otherwise x increments.
  - Window comparisons use 17-bit sums, so there is no wrap.
- VA fall in HEADER or IMAGE → DONE. FRAME_ERR is set if x≠0 or y≠PARAM_Y.
- DONE: pulses FRAME_DONE for one cycle, then → IDLE.
- Strobes in IDLE or DONE are ignored.
- FIFO full with a push pending: the word is dropped, OVERFLOW sets, and counters still advance.
- FIFO contents are never flushed except by RST. Words left in the FIFO at frame end drain normally.

## Timing
- Strobe in cycle n: word written to the FIFO at the n+1 edge. M_VALID is asserted from cycle n+2 when the FIFO was empty.
- Stream handshake: a transfer occurs when M_VALID & M_READY. M_DATA, M_HDR, M_SOF and M_EOL are held stable while M_VALID & !M_READY.
- Simultaneous push and pop on a full FIFO: the pop frees the slot and the push is accepted; no overflow.
- VA rise and a strobe in the same cycle: the strobe is ignored, because VA is registered.
- FRAME_DONE is asserted 2 cycles after the VA falling edge at the input.
- RST mid-frame: returns to IDLE next cycle and empties the FIFO. A new frame requires a fresh VA rise.
- Throughput: one strobe per cycle sustained with M_READY=1.

## Structure
- Package ccd_pkg holds:
  - the state enum (IDLE/HEADER/IMAGE/DONE);
  - the parameter width constant (16);
  - the FIFO word layout {HDR, SOF, EOL, DATA}, DATA_W+3 bits.
- Sub-module sync_fifo: single clock, synchronous reset, registered output, full/empty flags, width DATA_W+3, depth FIFO_DEPTH.
- Top level contains the FSM, the x/y counters, window compare, and sticky flags.

## Test plan
Small frame used below: X=8, Y=4, OFFSET 2,1, ACTIVE 4,2.
- Basic frame: 2 header strobes, then 32 image strobes, M_READY=1. Expect 2 M_HDR words, then 8 window words. The first window word is (2,1) with M_SOF. M_EOL on x=5 of rows 1 and 2. FRAME_DONE pulses once; FRAME_ERR=0.
- Short frame: VA falls after 29 image strobes. Expect FRAME_ERR=1 and FRAME_DONE pulses. The next VA rise clears FRAME_ERR.
- Backpressure: M_READY=0 for the whole frame with FIFO_DEPTH=4. Expect the first 4 words retained, OVERFLOW=1, and M_DATA stable. Releasing M_READY drains exactly those 4 words in order.
- Full-FIFO push and pop: FIFO full, strobe and pop in the same cycle. Expect no overflow and word order preserved.
- Reset mid-frame: RST asserted at image strobe 10. Expect all outputs 0 and M_VALID=0 next cycle. Strobes are ignored until the next VA rise.
- Window at frame edge: OFFSET_X=0, ACTIVE_X=8. Expect M_EOL on x=7 and a correct row increment with no dropped word.
